// File: rtl/weight_load_ctrl_if.sv
// weight_load_ctrl_if: host-write, array-load and status signals of the weight load controller
interface weight_load_ctrl_if #(
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_PE_ROWS = 8
);
    localparam int RW = $clog2(NUM_PE_ROWS);
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    logic          wr_valid;
    logic          wr_ready;
    logic          fifo_we;
    logic          load_req;
    logic          fifo_re;
    logic          row_we;
    logic [RW-1:0] row_sel;
    logic          load_busy;
    logic          load_done;
    logic [OW-1:0] occupancy;
    logic          err;
    modport master (
        output wr_valid, load_req,
        input  wr_ready, fifo_we, fifo_re, row_we, row_sel, load_busy, load_done, occupancy, err
    );
    modport slave (
        input  wr_valid, load_req,
        output wr_ready, fifo_we, fifo_re, row_we, row_sel, load_busy, load_done, occupancy, err
    );
endinterface

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: tracks weight FIFO occupancy and streams one tile into the PE rows per load request; optional sticky protocol error via WEIGHT_LOAD_ERR_EN
module weight_load_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_PE_ROWS = 8
) (
    input logic              clk,
    input logic              rstn,
    weight_load_ctrl_if.slave bus
);
    localparam int RW = $clog2(NUM_PE_ROWS);
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam logic [RW-1:0] LAST = RW'(NUM_PE_ROWS - 1);
    localparam logic [OW-1:0] FULL = OW'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t        state, state_nx;
    logic [RW-1:0] row_cnt;
    logic [OW-1:0] occ;
    logic          wr_ok, rd_ok;
    assign wr_ok = bus.wr_valid && (occ < FULL);
    assign rd_ok = (state == IDLE) && bus.load_req && (occ != '0);
    // state register
    always_ff @(posedge clk)
        state <= !rstn ? IDLE : state_nx;
    // next state: a read in IDLE starts a tile, the last row leads to a one-cycle DONE
    always_comb
        state_nx = state == IDLE  ? (rd_ok ? SHIFT : IDLE) :
                   state == SHIFT ? (row_cnt == LAST ? DONE : SHIFT) : IDLE;
    // row index counts only while shifting and rests at zero otherwise
    always_ff @(posedge clk)
        row_cnt <= (!rstn || state != SHIFT || row_cnt == LAST) ? '0 : row_cnt + 1'b1;
    // occupancy moves only when exactly one of write/read fires
    always_ff @(posedge clk)
        if (!rstn) occ <= '0;
        else if (wr_ok && !rd_ok) occ <= occ + 1'b1;
        else if (rd_ok && !wr_ok) occ <= occ - 1'b1;
    // outputs; load-side strobes are held low while reset is asserted
    always_comb begin
        bus.wr_ready  = occ < FULL;
        bus.fifo_we   = wr_ok;
        bus.fifo_re   = rstn && rd_ok;
        bus.row_we    = rstn && (state == SHIFT);
        bus.row_sel   = row_cnt;
        bus.load_busy = rstn && (state != IDLE);
        bus.load_done = rstn && (state == DONE);
        bus.occupancy = occ;
    end
`ifdef WEIGHT_LOAD_ERR_EN
    logic err_q;
    // sticky flag for a write into a full FIFO or a load request with nothing to load
    always_ff @(posedge clk)
        err_q <= !rstn ? 1'b0 : err_q | (bus.wr_valid && occ == FULL) |
                 (bus.load_req && state == IDLE && occ == '0);
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, entry count of the controlled weight FIFO.
REQ-002 Parameter NUM_PE_ROWS, default 8, PE rows loaded per weight tile.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 wr_valid  input  1  host offers one weight tile to the FIFO.
REQ-006 wr_ready  output  1  controller can accept a tile (occupancy < FIFO_DEPTH).
REQ-007 fifo_we  output  1  write_enable to the weight FIFO.
REQ-008 load_req  input  1  array requests the next weight tile.
REQ-009 fifo_re  output  1  read_enable to the weight FIFO.
REQ-010 row_we  output  1  write strobe for the selected PE row's weight register.
REQ-011 row_sel  output  $clog2(NUM_PE_ROWS)  index of the PE row being loaded.
REQ-012 load_busy  output  1  tile load in progress (state != IDLE).
REQ-013 load_done  output  1  one-cycle pulse at tile load completion.
REQ-014 occupancy  output  $clog2(FIFO_DEPTH+1)  tiles currently held in the FIFO.
REQ-015 err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-016 fifo_we SHALL equal wr_valid & wr_ready, combinationally, in the same cycle.
REQ-017 wr_ready SHALL be 1 when occupancy < FIFO_DEPTH, regardless of FSM state.
REQ-018 occupancy SHALL increment on fifo_we only, decrement on fifo_re only, hold when both or neither; it SHALL never exceed FIFO_DEPTH nor go below 0.
REQ-019 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-020 In IDLE with load_req=1 and occupancy>0, fifo_re SHALL be 1 combinationally that cycle (cycle T) and the next state SHALL be SHIFT; otherwise fifo_re=0 and the FSM stays in IDLE.
REQ-021 In IDLE with load_req=1 and occupancy=0, no read SHALL issue; the request SHALL wait until occupancy>0.
REQ-022 SHIFT SHALL last exactly NUM_PE_ROWS cycles (T+1..T+NUM_PE_ROWS) with row_we=1 and row_sel counting 0,1,...,NUM_PE_ROWS-1.
REQ-023 After the last row the FSM SHALL enter DONE for one cycle (T+NUM_PE_ROWS+1) with load_done=1, then return to IDLE.
REQ-024 fifo_re SHALL be 0 in SHIFT and DONE; back-to-back loads SHALL therefore be spaced NUM_PE_ROWS+2 cycles minimum.
REQ-025 Deassertion of load_req after acceptance SHALL NOT abort the load.
REQ-026 row_sel SHALL be 0 and row_we=0 outside SHIFT.
REQ-027 Host writes SHALL proceed concurrently with any FSM state.

Reset
REQ-028 While rstn=0 at a rising edge: state=IDLE, occupancy=0, row_sel=0, err=0.
REQ-029 During and after reset: fifo_re=0, row_we=0, load_done=0, load_busy=0, wr_ready=1 (once occupancy=0 is registered).
REQ-030 Reset asserted mid-load SHALL abandon the load with no load_done pulse.

Configuration
REQ-031 Macro WEIGHT_LOAD_ERR_EN: when defined, err SHALL set (sticky until reset) on wr_valid=1 while occupancy=FIFO_DEPTH, or load_req=1 in IDLE while occupancy=0.
REQ-032 Without WEIGHT_LOAD_ERR_EN, err SHALL be tied to 0 and no error logic SHALL be synthesized.

Verification
REQ-033 Reset, then 4 writes (FIFO_DEPTH=4) -> occupancy 1,2,3,4; wr_ready=0 after 4th; 5th wr_valid gives fifo_we=0.
REQ-034 occupancy=1, load_req pulse at cycle T -> fifo_re=1 at T, row_we=1 rows 0..7 at T+1..T+8, load_done at T+9, occupancy=0.
REQ-035 occupancy=4, simultaneous wr_valid and accepted load_req -> fifo_we=0, occupancy 4->3; with occupancy=2 -> both fire, occupancy stays 2.
REQ-036 load_req held with occupancy=0 for 5 cycles, then one write -> fifo_re issues the cycle after occupancy becomes 1.
REQ-037 rstn=0 at T+4 during SHIFT -> next cycle IDLE, row_we=0, no load_done, occupancy=0.
REQ-038 With WEIGHT_LOAD_ERR_EN: wr_valid at occupancy=4 -> err=1, stays 1 until rstn; without macro err=0 throughout.
